// File: rtl/inv_sub_bytes_if.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_if
// Handshake bundle for the time-multiplexed inverse SubBytes engine.
//   in_valid / in_ready / state_in    : input transfer of one 128-bit state
//   out_valid / out_ready / state_out : output transfer of the result
//   busy                              : engine is not idle
// Byte k of a state sits at [127-8k -: 8], k = 4*col + row.
// The master modport belongs to the block that supplies states and consumes
// results; the slave modport belongs to the engine.
// ---------------------------------------------------------------------------
interface inv_sub_bytes_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output busy
    );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_seq
// Time-multiplexed inverse SubBytes for the AES decryption datapath. A
// 128-bit state is captured, its 16 bytes are pushed through LANES shared
// inverse S-boxes over 16/LANES beats, and the result is offered downstream.
//
// Parameters
//   LANES : number of inverse S-box instances (1, 2, 4, 8 or 16)
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : inv_sub_bytes_if.slave (in_valid/in_ready/state_in,
//           out_valid/out_ready/state_out, busy)
// Build option
//   INV_SUB_INVSHIFT_EN : when defined, state_out is InvShiftRows(result),
//                         making the block a full InvShiftRows o InvSubBytes
//                         step; handshake and timing are unchanged.
// ---------------------------------------------------------------------------

// Single combinational inverse S-box.
module inv_s_box (
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);
    // Inverse S-box rows, indexed by the high nibble; byte n of a row is the
    // entry for low nibble n.
    localparam logic [127:0] ROW_0 = 128'h52096ad53036a538bf40a39e81f3d7fb;
    localparam logic [127:0] ROW_1 = 128'h7ce339829b2fff87348e4344c4dee9cb;
    localparam logic [127:0] ROW_2 = 128'h547b9432a6c2233dee4c950b42fac34e;
    localparam logic [127:0] ROW_3 = 128'h082ea16628d924b2765ba2496d8bd125;
    localparam logic [127:0] ROW_4 = 128'h72f8f66486689816d4a45ccc5d65b692;
    localparam logic [127:0] ROW_5 = 128'h6c704850fdedb9da5e154657a78d9d84;
    localparam logic [127:0] ROW_6 = 128'h90d8ab008cbcd30af7e45805b8b34506;
    localparam logic [127:0] ROW_7 = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
    localparam logic [127:0] ROW_8 = 128'h3a9111414f67dcea97f2cfcef0b4e673;
    localparam logic [127:0] ROW_9 = 128'h96ac7422e7ad3585e2f937e81c75df6e;
    localparam logic [127:0] ROW_A = 128'h47f11a711d29c5896fb7620eaa18be1b;
    localparam logic [127:0] ROW_B = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
    localparam logic [127:0] ROW_C = 128'h1fdda8338807c731b11210592780ec5f;
    localparam logic [127:0] ROW_D = 128'h60517fa919b54a0d2de57a9f93c99cef;
    localparam logic [127:0] ROW_E = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
    localparam logic [127:0] ROW_F = 128'h172b047eba77d626e169146355210c7d;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0:    row = ROW_0;
            4'h1:    row = ROW_1;
            4'h2:    row = ROW_2;
            4'h3:    row = ROW_3;
            4'h4:    row = ROW_4;
            4'h5:    row = ROW_5;
            4'h6:    row = ROW_6;
            4'h7:    row = ROW_7;
            4'h8:    row = ROW_8;
            4'h9:    row = ROW_9;
            4'hA:    row = ROW_A;
            4'hB:    row = ROW_B;
            4'hC:    row = ROW_C;
            4'hD:    row = ROW_D;
            4'hE:    row = ROW_E;
            4'hF:    row = ROW_F;
            default: row = 128'h0;
        endcase
        return row[127 - 8 * int'(x[3:0]) -: 8];
    endfunction

    // Table lookup.
    always_comb begin
        byte_out = inv_sbox(byte_in);
    end
endmodule

module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    inv_sub_bytes_if.slave bus
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] beat_r;
    logic [127:0]  src_r;
    logic [127:0]  result_r;
    logic [127:0]  state_out_s;
    logic          accept_s;
    logic          last_beat_s;
    logic [3:0]    lane_idx_s [LANES];
    logic [7:0]    sbox_in_s  [LANES];
    logic [7:0]    sbox_out_s [LANES];

    assign accept_s    = bus.in_valid && (state_r == IDLE);
    assign last_beat_s = (beat_r == LAST_BEAT);

    // Byte index handled by each lane this beat, and the matching source byte.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_idx_s[j] = 4'((int'(beat_r) * LANES) + j);
            sbox_in_s[j]  = src_r[127 - 8 * int'(lane_idx_s[j]) -: 8];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            inv_s_box u_inv_s_box (
                .byte_in  (sbox_in_s[g]),
                .byte_out (sbox_out_s[g])
            );
        end
    endgenerate

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_beat_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Beat counter: held at 0 outside BUSY, wraps to 0 after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_r <= '0;
        end else if (state_r == BUSY) begin
            if (last_beat_s) begin
                beat_r <= '0;
            end else begin
                beat_r <= beat_r + CW'(1);
            end
        end else begin
            beat_r <= '0;
        end
    end

    // Source capture on accept; per-beat write of only the lanes' bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r    <= 128'h0;
            result_r <= 128'h0;
        end else begin
            if (accept_s) begin
                src_r <= bus.state_in;
            end
            if (state_r == BUSY) begin
                for (int j = 0; j < LANES; j++) begin
                    result_r[127 - 8 * int'(lane_idx_s[j]) -: 8] <= sbox_out_s[j];
                end
            end
        end
    end

`ifdef INV_SUB_INVSHIFT_EN
    // Output byte (row r, col c) comes from result byte (row r, col c-r mod 4).
    generate
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                assign state_out_s[127 - 8 * (4 * c + r) -: 8] =
                    result_r[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
    endgenerate
`else
    assign state_out_s = result_r;
`endif

    // All outputs come straight from registers.
    assign bus.in_ready  = (state_r == IDLE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.state_out = state_out_s;
endmodule
